procb_queue: RTL

//  Per-thread circular queue of process_bytes (procb) records.

---
 rtl/procb_queue.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/procb_queue.sv
// procb_queue: per-thread circular queue of process_bytes records.
//
// Each thread owns a wrapping write pointer and read pointer. The read side
// also has a single read-ahead (lookup) pointer for the currently selected
// read thread, which lets the SHA block formatter consume records
// speculatively and then commit or rewind.
//
// Ports
//   CLK, RST_N     clock, asynchronous active-low reset
//   wr_thread_num  thread targeted by the write side
//   wr_en, din     write request and record data
//   wr_full        write thread is full (combinational)
//   wr_cnt         records stored in the write thread (combinational)
//   err            sticky: a write was attempted while full
//   rd_thread_num  thread targeted by the read side
//   lookup_en      advance the read-ahead pointer
//   rd_commit      release records up to the read-ahead pointer
//   rd_rewind      move the read-ahead pointer back to the read pointer
//   dout           record at the read-ahead pointer (combinational)
//   lookup_empty   no record at the read-ahead pointer (registered)
//   rd_cnt         committed records in the read thread (registered)
//
// Read-side handshake: dout is meaningful only while lookup_empty is 0.
// A lookup_en is accepted only when lookup_empty is 0; otherwise it is
// ignored. On the cycle rd_thread_num changes, lookup_en, rd_commit and
// rd_rewind are ignored and dout/lookup_empty become valid one cycle later.
module procb_queue #(
  parameter int N_THREADS     = 16,
  parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 8,
  parameter int A_WIDTH       = $clog2(DEPTH) + 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [N_THREADS_MSB:0]   wr_thread_num,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic                     wr_full,
  output logic [A_WIDTH-1:0]       wr_cnt,
  output logic                     err,
  input  logic [N_THREADS_MSB:0]   rd_thread_num,
  input  logic                     lookup_en,
  input  logic                     rd_commit,
  input  logic                     rd_rewind,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     lookup_empty,
  output logic [A_WIDTH-1:0]       rd_cnt
);

  localparam int MEM_AW = N_THREADS_MSB + A_WIDTH;

  logic [DATA_WIDTH-1:0]  mem [N_THREADS*DEPTH];
  logic [A_WIDTH-1:0]     wr_ptr_q [N_THREADS];
  logic [A_WIDTH-1:0]     rd_ptr_q [N_THREADS];
  logic [A_WIDTH-1:0]     lookup_ptr;
  logic [N_THREADS_MSB:0] rd_thread_prev;

  logic                   wr_accept;
  logic                   thread_change;
  logic                   lookup_acc;
  logic                   commit_do;
  logic [A_WIDTH-1:0]     rd_ptr_cur;
  logic [A_WIDTH-1:0]     rd_ptr_nxt;
  logic [A_WIDTH-1:0]     wr_ptr_rt_nxt;
  logic [A_WIDTH-1:0]     lookup_nxt;
  logic [MEM_AW-1:0]      wr_addr;
  logic [MEM_AW-1:0]      rd_addr;

  // Write side: full/count use the pre-commit read pointer, so a slot freed
  // by a commit only becomes writable on the following cycle.
  assign wr_cnt    = wr_ptr_q[wr_thread_num] - rd_ptr_q[wr_thread_num];
  assign wr_full   = (wr_cnt == A_WIDTH'(DEPTH));
  assign wr_accept = wr_en & ~wr_full;
  assign wr_addr   = {wr_thread_num, wr_ptr_q[wr_thread_num][A_WIDTH-2:0]};

  assign rd_addr   = {rd_thread_num, lookup_ptr[A_WIDTH-2:0]};
  assign dout      = mem[rd_addr];

  always_comb begin
    thread_change = (rd_thread_num != rd_thread_prev);
    rd_ptr_cur    = rd_ptr_q[rd_thread_num];
    lookup_acc    = 1'b0;
    commit_do     = 1'b0;
    lookup_nxt    = lookup_ptr;
    rd_ptr_nxt    = rd_ptr_cur;

    if (thread_change) begin
      // Restart speculation at the committed position of the new thread.
      lookup_nxt = rd_ptr_cur;
    end else if (rd_rewind) begin
      // Rewind wins over lookup_en and turns a same-cycle commit into a no-op.
      lookup_nxt = rd_ptr_cur;
    end else begin
      lookup_acc = lookup_en & ~lookup_empty;
      if (lookup_acc) begin
        lookup_nxt = lookup_ptr + A_WIDTH'(1);
      end
      if (rd_commit) begin
        commit_do  = 1'b1;
        rd_ptr_nxt = lookup_nxt;
      end
    end

    // Registered read status must see a same-cycle write into the rd thread.
    wr_ptr_rt_nxt = wr_ptr_q[rd_thread_num];
    if (wr_accept && (wr_thread_num == rd_thread_num)) begin
      wr_ptr_rt_nxt = wr_ptr_rt_nxt + A_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_accept) begin
      mem[wr_addr] <= din;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int t = 0; t < N_THREADS; t++) begin
        wr_ptr_q[t] <= '0;
        rd_ptr_q[t] <= '0;
      end
      lookup_ptr     <= '0;
      rd_thread_prev <= '0;
      err            <= 1'b0;
      lookup_empty   <= 1'b1;
      rd_cnt         <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_q[wr_thread_num] <= wr_ptr_q[wr_thread_num] + A_WIDTH'(1);
      end
      if (commit_do) begin
        rd_ptr_q[rd_thread_num] <= rd_ptr_nxt;
      end
      if (wr_en && wr_full) begin
        err <= 1'b1;
      end
      lookup_ptr     <= lookup_nxt;
      rd_thread_prev <= rd_thread_num;
      lookup_empty   <= (lookup_nxt == wr_ptr_rt_nxt);
      rd_cnt         <= wr_ptr_rt_nxt - rd_ptr_nxt;
    end
  end

endmodule
